// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared defaults for the switch debouncer
package sw_debounce_pkg;

    localparam int unsigned SW_WIDTH          = 16;
    localparam int unsigned SW_TICK_DIV       = 50000;
    localparam int unsigned SW_STABLE_SAMPLES = 4;

    // Per-bit sample counters are fixed at 4 bits; STABLE_SAMPLES tops out at 15.
    localparam int unsigned SW_CNT_W          = 4;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one switch lane: synchronizer, sample counter, debounced level, edge pulses
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = SW_STABLE_SAMPLES
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [SW_CNT_W-1:0] CNT_ACCEPT = SW_CNT_W'(STABLE_SAMPLES);

    logic                sync1_q, sync2_q;
    logic                db_q, db_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic [SW_CNT_W-1:0] cnt_q, cnt_d;
    logic [SW_CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + SW_CNT_W'(1);

    // Any matching sample restarts the run, so only an unbroken run of differing samples is accepted.
    always_comb begin
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (tick_i) begin
            if (sync2_q != db_q) begin
                if (cnt_inc == CNT_ACCEPT) begin
                    cnt_d  = '0;
                    db_d   = ~db_q;
                    rise_d = ~db_q;
                    fall_d = db_q;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - switch bank debouncer with a shared sample prescaler
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH          = SW_WIDTH,
    parameter int unsigned TICK_DIV       = SW_TICK_DIV,
    parameter int unsigned STABLE_SAMPLES = SW_STABLE_SAMPLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             tick
);

    localparam int unsigned    PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;

    // tick decodes the terminal count, so the first strobe lands TICK_DIV cycles after release.
    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .STABLE_SAMPLES (STABLE_SAMPLES)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .tick_i (tick),
            .raw_i  (sw_raw[g]),
            .db_o   (sw_db[g]),
            .rise_o (sw_rise[g]),
            .fall_o (sw_fall[g])
        );
    end

endmodule
